// File: rtl/cva6_rvfi_trace_fifo.sv
// -----------------------------------------------------------------------------
// cva6_rvfi_trace_fifo
//
// Collects the per-cycle retired-instruction records from the RVFI packer (one
// record per commit port) and serializes them into one in-order valid/ready
// stream for a tracer or DPI sink. Each record is tagged with a 64-bit
// retirement order number and the commit port it arrived on. The core is never
// stalled: when a cycle's records do not all fit, the whole cycle is dropped.
// A drop is reported through a sticky overflow flag and a saturating drop
// counter.
//
// Ports:
//   clk_i            clock
//   rst_i            synchronous active-high reset
//   commit_valid_i   per-port record valid
//   commit_record_i  per-port packed records, port p at [p*RecordWidth +: RecordWidth]
//   clear_i          clears overflow_o and drop_cnt_o
//   trace_valid_o    head record available
//   trace_ready_i    sink accepts the head record
//   trace_record_o   head record
//   trace_order_o    retirement order number of the head record
//   trace_port_o     commit port the head record arrived on
//   level_o          current occupancy
//   overflow_o       sticky: at least one record dropped
//   drop_cnt_o       saturating count of dropped records
// -----------------------------------------------------------------------------
module cva6_rvfi_trace_fifo #(
    parameter  int unsigned NrCommitPorts = 2,
    parameter  int unsigned RecordWidth   = 256,
    parameter  int unsigned Depth         = 8,
    parameter  int unsigned DropCntWidth  = 16,
    localparam int unsigned PortW         = (NrCommitPorts > 1) ? $clog2(NrCommitPorts) : 1,
    localparam int unsigned LevelW        = $clog2(Depth) + 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NrCommitPorts-1:0]             commit_valid_i,
    input  logic [NrCommitPorts*RecordWidth-1:0] commit_record_i,
    input  logic                                 clear_i,
    output logic                                 trace_valid_o,
    input  logic                                 trace_ready_i,
    output logic [RecordWidth-1:0]               trace_record_o,
    output logic [63:0]                          trace_order_o,
    output logic [PortW-1:0]                     trace_port_o,
    output logic [LevelW-1:0]                    level_o,
    output logic                                 overflow_o,
    output logic [DropCntWidth-1:0]              drop_cnt_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(NrCommitPorts + 1);

    // Entry storage
    logic [RecordWidth-1:0]  mem_rec   [Depth];
    logic [63:0]             mem_order [Depth];
    logic [PortW-1:0]        mem_port  [Depth];

    // Control state
    logic [PtrW-1:0]         wr_ptr_q;
    logic [PtrW-1:0]         rd_ptr_q;
    logic [LevelW-1:0]       level_q;
    logic [63:0]             order_cnt_q;
    logic                    overflow_q;
    logic [DropCntWidth-1:0] drop_cnt_q;

    // Last popped head, shown while the FIFO is empty
    logic [RecordWidth-1:0]  hold_rec_q;
    logic [63:0]             hold_order_q;
    logic [PortW-1:0]        hold_port_q;

    // Enqueue bookkeeping
    logic [CntW-1:0]         n_valid;
    logic [CntW-1:0]         slot_off [NrCommitPorts];
    logic [PtrW-1:0]         wr_idx   [NrCommitPorts];
    logic [LevelW-1:0]       free_slots;
    logic                    push;
    logic                    drop;
    logic                    pop;
    logic [DropCntWidth-1:0] drop_base;
    logic [DropCntWidth:0]   drop_sum;

    // Valid ports are compacted in ascending index order: each one's slot
    // offset is the number of valid ports below it. The same offset selects
    // both its storage slot and its order number.
    // NOTE: every always_comb output gets a default before any conditional
    // logic, so no path leaves a value unassigned and no latch is inferred;
    // blocking assignments here make the running count visible to the next
    // loop iteration.
    always_comb begin
        n_valid = '0;
        for (int p = 0; p < NrCommitPorts; p++) begin
            slot_off[p] = n_valid;
            wr_idx[p]   = wr_ptr_q + PtrW'(n_valid);
            n_valid     = n_valid + CntW'(commit_valid_i[p]);
        end
    end

    // All-or-nothing acceptance against the registered level only. A pop in
    // this cycle gives no credit, which keeps trace_ready_i out of the
    // acceptance path.
    assign free_slots = LevelW'(Depth) - level_q;
    assign push       = (n_valid != '0) && (free_slots >= LevelW'(n_valid));
    assign drop       = (n_valid != '0) && !(free_slots >= LevelW'(n_valid));
    assign pop        = trace_valid_o && trace_ready_i;

    // A drop coinciding with clear_i restarts the count from this drop.
    assign drop_base  = clear_i ? '0 : drop_cnt_q;
    assign drop_sum   = {1'b0, drop_base} + (DropCntWidth + 1)'(n_valid);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            order_cnt_q  <= '0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
            hold_rec_q   <= '0;
            hold_order_q <= '0;
            hold_port_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(n_valid);
            end
            if (pop) begin
                rd_ptr_q     <= rd_ptr_q + PtrW'(1);
                hold_rec_q   <= mem_rec[rd_ptr_q];
                hold_order_q <= mem_order[rd_ptr_q];
                hold_port_q  <= mem_port[rd_ptr_q];
            end
            level_q <= level_q + (push ? LevelW'(n_valid) : '0) - LevelW'(pop);

            // Every valid record consumes an order number, dropped or not.
            order_cnt_q <= order_cnt_q + 64'(n_valid);

            if (drop) begin
                overflow_q <= 1'b1;
                drop_cnt_q <= drop_sum[DropCntWidth] ? '1 : drop_sum[DropCntWidth-1:0];
            end else if (clear_i) begin
                overflow_q <= 1'b0;
                drop_cnt_q <= '0;
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; a slot is only ever
    // read after it has been written, and the empty-FIFO outputs come from the
    // reset hold registers instead.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            for (int p = 0; p < NrCommitPorts; p++) begin
                if (commit_valid_i[p]) begin
                    mem_rec[wr_idx[p]]   <= commit_record_i[p*RecordWidth +: RecordWidth];
                    mem_order[wr_idx[p]] <= order_cnt_q + 64'(slot_off[p]);
                    mem_port[wr_idx[p]]  <= PortW'(p);
                end
            end
        end
    end

    // First-word-fall-through head from registered storage
    assign trace_valid_o  = (level_q != '0);
    assign trace_record_o = trace_valid_o ? mem_rec[rd_ptr_q]   : hold_rec_q;
    assign trace_order_o  = trace_valid_o ? mem_order[rd_ptr_q] : hold_order_q;
    assign trace_port_o   = trace_valid_o ? mem_port[rd_ptr_q]  : hold_port_q;
    assign level_o        = level_q;
    assign overflow_o     = overflow_q;
    assign drop_cnt_o     = drop_cnt_q;

endmodule

// File: tb/tb_cva6_rvfi_trace_fifo.sv
// -----------------------------------------------------------------------------
// tb_cva6_rvfi_trace_fifo
//
// Self-checking bench for cva6_rvfi_trace_fifo with the default parameters
// (2 ports, 256-bit records, 8 entries, 16-bit drop counter). A queue-based
// reference model tracks contents, order numbers and drop accounting; inputs
// are driven on the falling edge and outputs compared on the next falling edge.
// -----------------------------------------------------------------------------
module tb_cva6_rvfi_trace_fifo;

    localparam int NP = 2;
    localparam int RW = 256;
    localparam int D  = 8;
    localparam int DW = 16;
    localparam int VW = 1 + 4 + 1 + DW + RW + 64 + 1;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic [NP-1:0]      commit_valid_i;
    logic [NP*RW-1:0]   commit_record_i;
    logic               clear_i;
    logic               trace_valid_o;
    logic               trace_ready_i;
    logic [RW-1:0]      trace_record_o;
    logic [63:0]        trace_order_o;
    logic [0:0]         trace_port_o;
    logic [3:0]         level_o;
    logic               overflow_o;
    logic [DW-1:0]      drop_cnt_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    cva6_rvfi_trace_fifo #(
        .NrCommitPorts(NP),
        .RecordWidth  (RW),
        .Depth        (D),
        .DropCntWidth (DW)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .commit_valid_i (commit_valid_i),
        .commit_record_i(commit_record_i),
        .clear_i        (clear_i),
        .trace_valid_o  (trace_valid_o),
        .trace_ready_i  (trace_ready_i),
        .trace_record_o (trace_record_o),
        .trace_order_o  (trace_order_o),
        .trace_port_o   (trace_port_o),
        .level_o        (level_o),
        .overflow_o     (overflow_o),
        .drop_cnt_o     (drop_cnt_o)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [RW-1:0] rec;
        logic [63:0]   order;
        logic [0:0]    port;
    } entry_t;

    entry_t        mq[$];
    logic [63:0]   m_order = '0;
    logic          m_ovf   = 1'b0;
    logic [DW-1:0] m_drop  = '0;

    function automatic void model_update(input logic [1:0] v, input logic [RW-1:0] r0,
                                         input logic [RW-1:0] r1, input logic rdy,
                                         input logic clr, input logic rs);
        int n;
        int s;
        bit accept;
        entry_t e;
        if (rs) begin
            mq.delete();
            m_order = '0;
            m_ovf   = 1'b0;
            m_drop  = '0;
            return;
        end
        n      = int'(v[0]) + int'(v[1]);
        accept = (D - mq.size()) >= n;
        if (mq.size() > 0 && rdy) void'(mq.pop_front());
        if (accept) begin
            if (v[0]) begin
                e.rec = r0; e.order = m_order; e.port = 1'b0;
                mq.push_back(e);
            end
            if (v[1]) begin
                e.rec = r1; e.order = m_order + 64'(int'(v[0])); e.port = 1'b1;
                mq.push_back(e);
            end
        end
        if (n > 0 && !accept) begin
            s      = (clr ? 0 : int'(m_drop)) + n;
            m_drop = (s > 65535) ? 16'hFFFF : 16'(s);
            m_ovf  = 1'b1;
        end else if (clr) begin
            m_drop = '0;
            m_ovf  = 1'b0;
        end
        m_order = m_order + 64'(n);
    endfunction

    function automatic logic [VW-1:0] model_view();
        if (mq.size() == 0) return {1'b0, 4'd0, m_ovf, m_drop, {(RW+65){1'b0}}};
        return {1'b1, 4'(mq.size()), m_ovf, m_drop, mq[0].rec, mq[0].order, mq[0].port};
    endfunction

    function automatic logic [VW-1:0] dut_view();
        if (!trace_valid_o) return {1'b0, level_o, overflow_o, drop_cnt_o, {(RW+65){1'b0}}};
        return {1'b1, level_o, overflow_o, drop_cnt_o, trace_record_o, trace_order_o, trace_port_o};
    endfunction

    function automatic logic [RW-1:0] rand_rec();
        logic [RW-1:0] r;
        for (int i = 0; i < RW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // One clock: drive on the falling edge, advance model at the rising edge,
    // return at the next falling edge where outputs are compared.
    task automatic step(input logic [1:0] v, input logic [RW-1:0] r0, input logic [RW-1:0] r1,
                        input logic rdy, input logic clr, input logic rs);
        commit_valid_i  = v;
        commit_record_i = {r1, r0};
        trace_ready_i   = rdy;
        clear_i         = clr;
        rst_i           = rs;
        @(posedge clk_i);
        model_update(v, r0, r1, rdy, clr, rs);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        step(2'b00, '0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({trace_valid_o, level_o, overflow_o, drop_cnt_o, trace_record_o, trace_order_o, trace_port_o} !== '0) begin
            errors++;
            $display("FAIL reset_values: got valid=%b level=%0d ovf=%b drop=%0d order=%0d port=%0d, want all zero",
                     trace_valid_o, level_o, overflow_o, drop_cnt_o, trace_order_o, trace_port_o);
        end
    endtask

    task automatic test_dual_push();
        logic [RW-1:0] a, b;
        a = rand_rec();
        b = rand_rec();
        do_reset();
        step(2'b11, a, b, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({trace_valid_o, level_o, trace_record_o, trace_order_o, trace_port_o} !== {1'b1, 4'd2, a, 64'd0, 1'b0}) begin
            errors++;
            $display("FAIL dual_push_head_a: got v=%b lvl=%0d ord=%0d port=%0d, want v=1 lvl=2 ord=0 port=0 rec A",
                     trace_valid_o, level_o, trace_order_o, trace_port_o);
        end
        step(2'b00, '0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({trace_valid_o, level_o, trace_record_o, trace_order_o, trace_port_o} !== {1'b1, 4'd1, b, 64'd1, 1'b1}) begin
            errors++;
            $display("FAIL dual_push_head_b: got v=%b lvl=%0d ord=%0d port=%0d, want v=1 lvl=1 ord=1 port=1 rec B",
                     trace_valid_o, level_o, trace_order_o, trace_port_o);
        end
        step(2'b00, '0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({trace_valid_o, level_o} !== {1'b0, 4'd0}) begin
            errors++;
            $display("FAIL dual_push_empty: got v=%b lvl=%0d, want v=0 lvl=0", trace_valid_o, level_o);
        end
    endtask

    task automatic test_port1_only();
        logic [RW-1:0] c;
        c = rand_rec();
        do_reset();
        step(2'b10, '0, c, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({trace_valid_o, trace_record_o, trace_order_o, trace_port_o} !== {1'b1, c, 64'd0, 1'b1}) begin
            errors++;
            $display("FAIL port1_only: got v=%b ord=%0d port=%0d, want v=1 ord=0 port=1 rec C",
                     trace_valid_o, trace_order_o, trace_port_o);
        end
    endtask

    task automatic test_backpressure();
        logic [RW-1:0] r [3];
        for (int i = 0; i < 3; i++) r[i] = rand_rec();
        do_reset();
        step(2'b11, r[0], r[1], 1'b0, 1'b0, 1'b0);
        step(2'b01, r[2], '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(2'b00, '0, '0, 1'b0, 1'b0, 1'b0);
            checks++;
            if ({trace_valid_o, level_o, trace_record_o, trace_order_o} !== {1'b1, 4'd3, r[0], 64'd0}) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: got v=%b lvl=%0d ord=%0d, want v=1 lvl=3 ord=0",
                         i, trace_valid_o, level_o, trace_order_o);
            end
        end
        for (int i = 1; i <= 3; i++) begin
            step(2'b00, '0, '0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (i < 3 && {trace_valid_o, trace_record_o, trace_order_o} !== {1'b1, r[i], 64'(i)}) begin
                errors++;
                $display("FAIL backpressure_drain[%0d]: got v=%b ord=%0d, want v=1 ord=%0d",
                         i, trace_valid_o, trace_order_o, i);
            end else if (i == 3 && trace_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_drain_empty: got v=%b, want 0", trace_valid_o);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        step(2'b11, rand_rec(), rand_rec(), 1'b0, 1'b0, 1'b0);
        step(2'b11, rand_rec(), rand_rec(), 1'b0, 1'b0, 1'b0);
        step(2'b11, rand_rec(), rand_rec(), 1'b0, 1'b0, 1'b0);
        step(2'b01, rand_rec(), '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({level_o, overflow_o, drop_cnt_o} !== {4'd7, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL overflow_fill: got lvl=%0d ovf=%b drop=%0d, want lvl=7 ovf=0 drop=0",
                     level_o, overflow_o, drop_cnt_o);
        end
        step(2'b11, rand_rec(), rand_rec(), 1'b0, 1'b0, 1'b0);
        checks++;
        if ({level_o, overflow_o, drop_cnt_o} !== {4'd7, 1'b1, 16'd2}) begin
            errors++;
            $display("FAIL overflow_drop: got lvl=%0d ovf=%b drop=%0d, want lvl=7 ovf=1 drop=2",
                     level_o, overflow_o, drop_cnt_o);
        end
        step(2'b01, rand_rec(), '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({level_o, overflow_o, drop_cnt_o} !== {4'd8, 1'b1, 16'd2}) begin
            errors++;
            $display("FAIL overflow_refill: got lvl=%0d ovf=%b drop=%0d, want lvl=8 ovf=1 drop=2",
                     level_o, overflow_o, drop_cnt_o);
        end
    endtask

    task automatic test_full_pop();
        step(2'b01, rand_rec(), '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({trace_valid_o, level_o, drop_cnt_o, trace_order_o} !== {1'b1, 4'd7, 16'd3, 64'd1}) begin
            errors++;
            $display("FAIL full_pop: got v=%b lvl=%0d drop=%0d ord=%0d, want v=1 lvl=7 drop=3 ord=1",
                     trace_valid_o, level_o, drop_cnt_o, trace_order_o);
        end
    endtask

    task automatic test_clear_collision();
        step(2'b01, rand_rec(), '0, 1'b0, 1'b0, 1'b0);
        step(2'b11, rand_rec(), rand_rec(), 1'b0, 1'b0, 1'b0);
        checks++;
        if ({level_o, overflow_o, drop_cnt_o} !== {4'd8, 1'b1, 16'd5}) begin
            errors++;
            $display("FAIL clear_setup: got lvl=%0d ovf=%b drop=%0d, want lvl=8 ovf=1 drop=5",
                     level_o, overflow_o, drop_cnt_o);
        end
        step(2'b11, rand_rec(), rand_rec(), 1'b0, 1'b1, 1'b0);
        checks++;
        if ({overflow_o, drop_cnt_o} !== {1'b1, 16'd2}) begin
            errors++;
            $display("FAIL clear_vs_drop: got ovf=%b drop=%0d, want ovf=1 drop=2", overflow_o, drop_cnt_o);
        end
        step(2'b00, '0, '0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({level_o, overflow_o, drop_cnt_o} !== {4'd8, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL clear_alone: got lvl=%0d ovf=%b drop=%0d, want lvl=8 ovf=0 drop=0",
                     level_o, overflow_o, drop_cnt_o);
        end
    endtask

    // Stored orders after the drop scenarios: 1..6, then 9 (7,8 dropped),
    // then 11 (10 dropped).
    task automatic test_order_gap();
        logic [63:0] exp_ord [8];
        exp_ord = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd9, 64'd11};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({trace_valid_o, trace_order_o} !== {1'b1, exp_ord[i]} || dut_view() !== model_view()) begin
                errors++;
                $display("FAIL order_gap[%0d]: got v=%b ord=%0d, want v=1 ord=%0d", i, trace_valid_o, trace_order_o, exp_ord[i]);
            end
            step(2'b00, '0, '0, 1'b1, 1'b0, 1'b0);
        end
        checks++;
        if ({trace_valid_o, level_o} !== {1'b0, 4'd0}) begin
            errors++;
            $display("FAIL order_gap_empty: got v=%b lvl=%0d, want v=0 lvl=0", trace_valid_o, level_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [RW-1:0] x;
        x = rand_rec();
        do_reset();
        step(2'b11, rand_rec(), rand_rec(), 1'b0, 1'b0, 1'b0);
        step(2'b11, rand_rec(), rand_rec(), 1'b0, 1'b0, 1'b0);
        step(2'b11, rand_rec(), rand_rec(), 1'b0, 1'b0, 1'b1);
        checks++;
        if ({trace_valid_o, level_o, overflow_o, drop_cnt_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid_state: got v=%b lvl=%0d ovf=%b drop=%0d, want all zero",
                     trace_valid_o, level_o, overflow_o, drop_cnt_o);
        end
        step(2'b01, x, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({trace_valid_o, level_o, trace_record_o, trace_order_o, trace_port_o} !== {1'b1, 4'd1, x, 64'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_order: got v=%b lvl=%0d ord=%0d port=%0d, want v=1 lvl=1 ord=0 port=0",
                     trace_valid_o, level_o, trace_order_o, trace_port_o);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 4; i++) step(2'b11, rand_rec(), rand_rec(), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 32767; i++) step(2'b11, '0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (drop_cnt_o !== 16'd65534) begin
            errors++;
            $display("FAIL saturation_before: got drop=%0d, want 65534", drop_cnt_o);
        end
        step(2'b11, '0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (drop_cnt_o !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturation_hit: got drop=%0d, want 65535", drop_cnt_o);
        end
        step(2'b01, '0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({drop_cnt_o, overflow_o, level_o} !== {16'hFFFF, 1'b1, 4'd8}) begin
            errors++;
            $display("FAIL saturation_hold: got drop=%0d ovf=%b lvl=%0d, want 65535 1 8",
                     drop_cnt_o, overflow_o, level_o);
        end
    endtask

    task automatic test_random();
        logic [1:0] v;
        logic       rdy, clr, rs;
        int         rdy_pct;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            rdy_pct = ((i / 250) % 2 == 0) ? 80 : 30;
            v   = 2'($urandom_range(0, 3));
            rdy = ($urandom_range(0, 99) < rdy_pct);
            clr = ($urandom_range(0, 19) == 0);
            rs  = ($urandom_range(0, 299) == 0);
            step(v, rand_rec(), rand_rec(), rdy, clr, rs);
            checks++;
            if (dut_view() !== model_view()) begin
                errors++;
                $display("FAIL random[%0d]: dut=%h model=%h", i, dut_view(), model_view());
            end
        end
    endtask

    initial begin
        rst_i           = 1'b1;
        commit_valid_i  = '0;
        commit_record_i = '0;
        clear_i         = 1'b0;
        trace_ready_i   = 1'b0;
        @(negedge clk_i);
        test_reset();
        test_dual_push();
        test_port1_only();
        test_backpressure();
        test_overflow();
        test_full_pop();
        test_clear_collision();
        test_order_gap();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
